// File: rtl/fcfs_request_queue.sv
// Per-requestor FIFO front end for the FCFS weighted round-robin arbiter.
// Stamps each entry with a priority class and arrival time; reports heads and the oldest one.
module fcfs_request_queue #(
    parameter int Requestors = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [Requestors-1:0]                    in_valid,
    input  logic [Requestors*DATA_W-1:0]             in_data,
    input  logic [Requestors*3-1:0]                  in_prior,
    output logic [Requestors-1:0]                    in_ready,
    input  logic [Requestors-1:0]                    pop,
    output logic [Requestors-1:0]                    req,
    output logic [Requestors*8-1:0]                  weights,
    output logic [Requestors*DATA_W-1:0]             head_data,
    output logic [Requestors*3-1:0]                  head_prior,
    output logic [Requestors*32-1:0]                 head_time,
    output logic [3:0]                               oldest_idx,
    output logic                                     oldest_valid,
    output logic [Requestors*($clog2(DEPTH)+1)-1:0]  count,
    output logic                                     overflow,
    output logic                                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] PRIO_LO  = 3'b001;
    localparam logic [2:0] PRIO_MED = 3'b010;
    localparam logic [2:0] PRIO_HI  = 3'b100;

    logic [31:0]       now;
    logic [DATA_W-1:0] mem_data  [Requestors][DEPTH];
    logic [2:0]        mem_prior [Requestors][DEPTH];
    logic [31:0]       mem_time  [Requestors][DEPTH];
    logic [PTR_W-1:0]  wr_ptr    [Requestors];
    logic [PTR_W-1:0]  rd_ptr    [Requestors];
    logic [CNT_W-1:0]  cnt       [Requestors];

    logic [Requestors-1:0] empty;
    logic [Requestors-1:0] push_en;
    logic [Requestors-1:0] pop_en;
    logic [DATA_W-1:0]     hd_data  [Requestors];
    logic [2:0]            hd_prior [Requestors];
    logic [31:0]           hd_time  [Requestors];

    function automatic logic [2:0] sanitize(input logic [2:0] p);
        case (p)
            PRIO_LO, PRIO_MED, PRIO_HI: return p;
            default:                    return PRIO_LO;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < Requestors; i++) begin
            empty[i]    = (cnt[i] == '0);
            in_ready[i] = (cnt[i] != CNT_W'(DEPTH));
            push_en[i]  = in_valid[i] && in_ready[i];
            pop_en[i]   = pop[i] && !empty[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            now       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < Requestors; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            now <= now + 32'd1;
            if (|(in_valid & ~in_ready)) overflow <= 1'b1;
            if (|(pop & empty))          underflow <= 1'b1;
            for (int i = 0; i < Requestors; i++) begin
                if (push_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop_en[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push_en[i], pop_en[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // NOTE: entry storage has no reset; emptiness comes from the counts, and heads are masked while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Requestors; i++) begin
            if (push_en[i] && !reset) begin
                mem_data[i][wr_ptr[i]]  <= in_data[i*DATA_W +: DATA_W];
                mem_prior[i][wr_ptr[i]] <= sanitize(in_prior[i*3 +: 3]);
                mem_time[i][wr_ptr[i]]  <= now;
            end
        end
    end

    // NOTE: every combinational output gets a value on every path, so no latches are inferred.
    always_comb begin
        for (int i = 0; i < Requestors; i++) begin
            hd_data[i]  = empty[i] ? '0 : mem_data[i][rd_ptr[i]];
            hd_prior[i] = empty[i] ? '0 : mem_prior[i][rd_ptr[i]];
            hd_time[i]  = empty[i] ? '0 : mem_time[i][rd_ptr[i]];
            req[i]                         = !empty[i];
            head_data[i*DATA_W +: DATA_W]  = hd_data[i];
            head_prior[i*3 +: 3]           = hd_prior[i];
            head_time[i*32 +: 32]          = hd_time[i];
            weights[i*8 +: 8]              = {5'b0, hd_prior[i]};
            count[i*CNT_W +: CNT_W]        = cnt[i];
        end
    end

    // Age is taken modulo 2^32 so the comparison survives timestamp wrap; strict > keeps lowest index on ties.
    always_comb begin
        logic [31:0] best_age;
        logic [31:0] age;
        logic        found;
        best_age   = '0;
        age        = '0;
        found      = 1'b0;
        oldest_idx = '0;
        for (int i = 0; i < Requestors; i++) begin
            age = now - hd_time[i];
            if (!empty[i] && (!found || age > best_age)) begin
                found      = 1'b1;
                best_age   = age;
                oldest_idx = 4'(i);
            end
        end
        oldest_valid = |req;
    end

endmodule

// File: tb/tb_fcfs_request_queue.sv
// Bench for fcfs_request_queue: directed table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_fcfs_request_queue;

    localparam int R     = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = 3;

    logic            clk;
    logic            reset;
    logic [R-1:0]    in_valid;
    logic [R*DW-1:0] in_data;
    logic [R*3-1:0]  in_prior;
    logic [R-1:0]    in_ready;
    logic [R-1:0]    pop;
    logic [R-1:0]    req;
    logic [R*8-1:0]  weights;
    logic [R*DW-1:0] head_data;
    logic [R*3-1:0]  head_prior;
    logic [R*32-1:0] head_time;
    logic [3:0]      oldest_idx;
    logic            oldest_valid;
    logic [R*CW-1:0] count;
    logic            overflow;
    logic            underflow;

    fcfs_request_queue #(.Requestors(R), .DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_prior(in_prior), .in_ready(in_ready),
        .pop(pop), .req(req), .weights(weights),
        .head_data(head_data), .head_prior(head_prior), .head_time(head_time),
        .oldest_idx(oldest_idx), .oldest_valid(oldest_valid),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [2:0]    p;
        logic [31:0]   t;
    } entry_t;

    entry_t      q [R][$];
    logic [31:0] m_now;
    logic        m_ovf;
    logic        m_unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < R; i++) q[i].delete();
        m_now = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        for (int i = 0; i < R; i++) begin
            int     sz;
            entry_t e;
            logic [2:0] pr;
            sz = q[i].size();
            if (pop[i]) begin
                if (sz == 0) m_unf = 1'b1;
                else void'(q[i].pop_front());
            end
            if (in_valid[i]) begin
                if (sz == DEPTH) m_ovf = 1'b1;
                else begin
                    pr  = in_prior[i*3 +: 3];
                    e.d = in_data[i*DW +: DW];
                    e.p = (pr inside {3'b001, 3'b010, 3'b100}) ? pr : 3'b001;
                    e.t = m_now;
                    q[i].push_back(e);
                end
            end
        end
        m_now = m_now + 32'd1;
    endtask

    task automatic compare_model();
        logic [R-1:0] e_req;
        logic [31:0]  best_age;
        logic [31:0]  age;
        int           best;
        bit           found;
        entry_t       e;
        e_req = '0;
        best = 0;
        best_age = '0;
        found = 0;
        for (int i = 0; i < R; i++) begin
            int sz;
            sz = q[i].size();
            e_req[i] = (sz > 0);
            if (sz > 0) e = q[i][0];
            else begin
                e.d = '0; e.p = '0; e.t = '0;
            end
            check($sformatf("ready[%0d]", i), 64'(in_ready[i]), 64'(sz != DEPTH));
            check($sformatf("count[%0d]", i), 64'(count[i*CW +: CW]), 64'(sz));
            check($sformatf("head_data[%0d]", i), 64'(head_data[i*DW +: DW]), 64'(e.d));
            check($sformatf("head_prior[%0d]", i), 64'(head_prior[i*3 +: 3]), 64'(e.p));
            check($sformatf("head_time[%0d]", i), 64'(head_time[i*32 +: 32]), 64'(e.t));
            check($sformatf("weights[%0d]", i), 64'(weights[i*8 +: 8]), 64'(e.p));
            if (sz > 0) begin
                age = m_now - e.t;
                if (!found || age > best_age) begin
                    found = 1; best_age = age; best = i;
                end
            end
        end
        check("req", 64'(req), 64'(e_req));
        check("oldest_idx", 64'(oldest_idx), 64'(best));
        check("oldest_valid", 64'(oldest_valid), 64'(found));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("underflow", 64'(underflow), 64'(m_unf));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        in_valid = '0;
        in_data  = '0;
        in_prior = '0;
        pop      = '0;
    endtask

    task automatic set_push(input int ch, input logic [DW-1:0] d, input logic [2:0] p);
        in_valid[ch]        = 1'b1;
        in_data[ch*DW +: DW] = d;
        in_prior[ch*3 +: 3] = p;
    endtask

    // Inputs are driven at the falling edge; the model follows the rising edge, outputs are compared at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [R-1:0]  valid;
        logic [DW-1:0] data;
        logic [2:0]    prior;
        logic [R-1:0]  pop;
        logic [R-1:0]  exp_req;
        logic [R-1:0]  exp_ready;
        logic [CW-1:0] exp_cnt3;
        logic [DW-1:0] exp_head3;
        logic [2:0]    exp_prior3;
        logic          exp_ovf;
        logic          exp_unf;
    } vec_t;

    vec_t vecs [11];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Channel 3: fill to depth, overflow, drain in order, underflow, then push an illegal priority.
        vecs[0]  = '{4'b1000, 8'h30, 3'b100, 4'b0000, 4'b1000, 4'b1111, 3'd1, 8'h30, 3'b100, 1'b0, 1'b0};
        vecs[1]  = '{4'b1000, 8'h31, 3'b010, 4'b0000, 4'b1000, 4'b1111, 3'd2, 8'h30, 3'b100, 1'b0, 1'b0};
        vecs[2]  = '{4'b1000, 8'h32, 3'b001, 4'b0000, 4'b1000, 4'b1111, 3'd3, 8'h30, 3'b100, 1'b0, 1'b0};
        vecs[3]  = '{4'b1000, 8'h33, 3'b100, 4'b0000, 4'b1000, 4'b0111, 3'd4, 8'h30, 3'b100, 1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 8'h34, 3'b010, 4'b0000, 4'b1000, 4'b0111, 3'd4, 8'h30, 3'b100, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 8'h00, 3'b000, 4'b1000, 4'b1000, 4'b1111, 3'd3, 8'h31, 3'b010, 1'b1, 1'b0};
        vecs[6]  = '{4'b0000, 8'h00, 3'b000, 4'b1000, 4'b1000, 4'b1111, 3'd2, 8'h32, 3'b001, 1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 8'h00, 3'b000, 4'b1000, 4'b1000, 4'b1111, 3'd1, 8'h33, 3'b100, 1'b1, 1'b0};
        vecs[8]  = '{4'b0000, 8'h00, 3'b000, 4'b1000, 4'b0000, 4'b1111, 3'd0, 8'h00, 3'b000, 1'b1, 1'b0};
        vecs[9]  = '{4'b0000, 8'h00, 3'b000, 4'b1000, 4'b0000, 4'b1111, 3'd0, 8'h00, 3'b000, 1'b1, 1'b1};
        vecs[10] = '{4'b1000, 8'h77, 3'b011, 4'b0000, 4'b1000, 4'b1111, 3'd1, 8'h77, 3'b001, 1'b1, 1'b1};

        reset = 1'b1;
        clear_inputs();

        // Reset state
        do_reset();
        check("reset req", 64'(req), 64'h0);
        check("reset in_ready", 64'(in_ready), 64'hF);
        check("reset count", 64'(count), 64'h0);
        check("reset oldest_valid", 64'(oldest_valid), 64'h0);

        // Push into an empty channel at now=3
        idle(3);
        set_push(2, 8'h5A, 3'b100);
        cycle();
        check("t1 req", 64'(req), 64'b0100);
        check("t1 head_data2", 64'(head_data[23:16]), 64'h5A);
        check("t1 head_prior2", 64'(head_prior[8:6]), 64'b100);
        check("t1 weights2", 64'(weights[23:16]), 64'h04);
        check("t1 head_time2", 64'(head_time[95:64]), 64'd3);
        check("t1 oldest_idx", 64'(oldest_idx), 64'd2);

        // Oldest selection across channels, then pop the oldest
        do_reset();
        idle(5);
        set_push(1, 8'h11, 3'b010);
        cycle();
        idle(4);
        set_push(0, 8'h10, 3'b001);
        cycle();
        check("t2 head_time1", 64'(head_time[63:32]), 64'd5);
        check("t2 head_time0", 64'(head_time[31:0]), 64'd10);
        check("t2 oldest before pop", 64'(oldest_idx), 64'd1);
        check("t2 count1 before pop", 64'(count[5:3]), 64'd1);
        clear_inputs();
        pop[1] = 1'b1;
        cycle();
        check("t2 count1 after pop", 64'(count[5:3]), 64'd0);
        check("t2 req1 after pop", 64'(req[1]), 64'd0);
        check("t2 oldest after pop", 64'(oldest_idx), 64'd0);

        // Table: fill, overflow, ordered drain, underflow, priority sanitizing on channel 3
        do_reset();
        for (int v = 0; v < 11; v++) begin
            clear_inputs();
            in_valid = vecs[v].valid;
            in_data  = {vecs[v].data, 24'h0};
            in_prior = {vecs[v].prior, 9'b0};
            pop      = vecs[v].pop;
            cycle();
            check($sformatf("tbl%0d req", v), 64'(req), 64'(vecs[v].exp_req));
            check($sformatf("tbl%0d in_ready", v), 64'(in_ready), 64'(vecs[v].exp_ready));
            check($sformatf("tbl%0d count3", v), 64'(count[11:9]), 64'(vecs[v].exp_cnt3));
            check($sformatf("tbl%0d head_data3", v), 64'(head_data[31:24]), 64'(vecs[v].exp_head3));
            check($sformatf("tbl%0d head_prior3", v), 64'(head_prior[11:9]), 64'(vecs[v].exp_prior3));
            check($sformatf("tbl%0d overflow", v), 64'(overflow), 64'(vecs[v].exp_ovf));
            check($sformatf("tbl%0d underflow", v), 64'(underflow), 64'(vecs[v].exp_unf));
        end

        // Simultaneous push and pop at count=2 keeps occupancy steady
        do_reset();
        set_push(0, 8'hA0, 3'b010);
        cycle();
        set_push(0, 8'hA1, 3'b010);
        cycle();
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            set_push(0, 8'(8'hA2 + k), 3'b001);
            pop[0] = 1'b1;
            cycle();
            check($sformatf("t4 count0 k%0d", k), 64'(count[2:0]), 64'd2);
            check($sformatf("t4 head0 k%0d", k), 64'(head_data[7:0]), 64'(8'hA1 + k));
        end

        // Timestamp wrap: age comparison stays correct across FFFF_FFFF -> 0
        do_reset();
        force dut.now = 32'hFFFF_FFFE;
        #1;
        release dut.now;
        m_now = 32'hFFFF_FFFE;
        set_push(1, 8'hB1, 3'b100);
        cycle();
        idle(3);
        set_push(0, 8'hB0, 3'b100);
        cycle();
        check("t6 head_time1", 64'(head_time[63:32]), 64'hFFFF_FFFE);
        check("t6 head_time0", 64'(head_time[31:0]), 64'd2);
        check("t6 oldest across wrap", 64'(oldest_idx), 64'd1);

        // Asynchronous reset in the middle of a push/pop cycle
        in_valid = '1;
        in_data  = 32'hC3C2_C1C0;
        in_prior = 12'b100_010_001_100;
        pop      = 4'b0011;
        #2;
        reset = 1'b1;
        #1;
        check("t6 req after async reset", 64'(req), 64'h0);
        check("t6 count after async reset", 64'(count), 64'h0);
        check("t6 ready after async reset", 64'(in_ready), 64'hF);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        compare_model();
        set_push(0, 8'hD0, 3'b010);
        cycle();
        check("t6 first stamp after reset", 64'(head_time[31:0]), 64'd0);

        // Randomized traffic against the model, with varying push/pop bias
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [R-1:0] v_mask;
            logic [R-1:0] p_mask;
            v_mask   = 4'($urandom);
            p_mask   = 4'($urandom);
            if (n % 200 < 70)       p_mask = p_mask & 4'($urandom);
            else if (n % 200 < 140) v_mask = v_mask & 4'($urandom);
            in_valid = v_mask;
            pop      = p_mask;
            in_data  = $urandom;
            in_prior = 12'($urandom);
            cycle();
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fcfs_request_queue.md
Name: fcfs_request_queue

Overview:
- Upstream stage of the FCFS weighted round-robin arbiter.
- Holds one FIFO per requestor. Each entry is stamped on arrival with a priority class and a 32-bit arrival time.
- Presents the head-of-queue state to the arbiter as the req vector, per-requestor weights, head priority and head timestamp.
- Computes the oldest pending requestor for first-come-first-served tie-breaking. Pops an entry when downstream signals that the transfer has completed.

Parameters:
- Requestors, 4, number of requestor channels.
- DEPTH, 4, entries per FIFO; must be a power of 2 and at least 2.
- DATA_W, 8, payload width in bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  Requestors  per-channel push request.
- in_data  input  Requestors*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- in_prior  input  Requestors*3  per-channel priority_t encoding: LO=001, MED=010, HI=100.
- in_ready  output  Requestors  per-channel "not full".
- pop  input  Requestors  pulse that removes the head entry of each set channel.
- req  output  Requestors  bit i = FIFO i is non-empty; drives the arbiter req.
- weights  output  Requestors*8  channel i = {5'b0, head_prior[i]}; drives the arbiter weights.
- head_data  output  Requestors*DATA_W  head payload per channel.
- head_prior  output  Requestors*3  head priority per channel.
- head_time  output  Requestors*32  arrival timestamp of the head entry per channel.
- oldest_idx  output  4  index of the oldest non-empty head.
- oldest_valid  output  1  high when any req bit is set.
- count  output  Requestors*($clog2(DEPTH)+1)  occupancy per channel.
- overflow  output  1  sticky: a push was attempted while the channel was full.
- underflow  output  1  sticky: a pop was attempted on an empty channel.

Behaviour:
- Reset state:
  - all FIFOs empty; count=0; req=0; in_ready=all 1s.
  - head_data, head_prior and head_time read as 0 for empty channels; weights=0.
  - oldest_idx=0; oldest_valid=0; overflow=0; underflow=0.
  - timestamp counter now=0.
- Timestamp counter now: 32-bit, increments every cycle, wraps from FFFF_FFFF to 0.
- Push:
  - A push occurs on channel i when in_valid[i] && in_ready[i] at a clock edge.
  - The stored entry is {in_data, sanitized prior, now}, where now is the value before the increment at that edge.
  - Sanitizing: any in_prior that is not 001, 010 or 100 is stored as LO (001).
- Ready: in_ready[i] = count[i] != DEPTH. It is combinational from state and does not depend on pop.
- Push when full: in_valid[i] && !in_ready[i] drops the data, leaves state unchanged and sets overflow.
- Pop:
  - pop[i] with count[i] > 0 advances the read pointer at the edge.
  - pop[i] with count[i] == 0 is ignored and sets underflow.
- Simultaneous push and pop on one channel (not full, not empty): both take effect and count is unchanged.
- Pointers: read and write pointers wrap modulo DEPTH.
- Latency:
  - A push into an empty FIFO makes req[i], head_* and weights valid on the cycle after the edge. There is no fall-through.
  - A pop updates head_* to the next entry on the cycle after the edge.
- Oldest selection (combinational over non-empty heads):
  - age_i = now - head_time[i], computed modulo 2^32 so it is wrap-safe.
  - The largest age wins; ties go to the lowest index.
  - oldest_valid = |req. When no head is non-empty, oldest_idx=0.
- Independence: channels are fully independent; multiple pushes and pops may occur in the same cycle.
- Sticky flags: overflow and underflow clear only on reset.
- Reset mid-operation: asserting reset empties every FIFO regardless of in-flight push or pop. The first push after deassertion is stamped from now=0.

Test Plan:
1. Reset, then push ch2 data 0x5A with prior HI at now=3 -> next cycle req=0100, head_data[2]=0x5A, head_prior[2]=100, weights[2]=0x04, head_time[2]=3, oldest_idx=2.
2. Push ch0 at now=10 and ch1 at now=5, then pop ch1 -> oldest_idx=1 before the pop and 0 after; count[1] goes 1->0 and req[1] falls on the next cycle.
3. Push ch3 five times with DEPTH=4 -> in_ready[3]=0 after the 4th push; the 5th push is dropped; overflow=1; count[3]=4; the FIFO pops 4 entries in push order.
4. Hold in_valid[0] and pop[0] together at count=2 for 6 cycles -> count stays 2 and head_data follows the pushed sequence delayed by 2 entries.
5. Push with in_prior=011 -> head_prior=001 and weights=0x01. Then pop an empty channel -> underflow=1, other state unchanged.
6. Force now=FFFF_FFFE, push ch1, let now wrap to 2, push ch0 -> oldest_idx=1 (age 4 vs 0). Then assert reset mid-push -> all req=0 and count=0 immediately.
